// File: rtl/gfx_pkg.sv
// Shared graphics constants and blitter state encoding, reused by the
// object blocks (player, enemies) and the framebuffer writer.
package gfx_pkg;

  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;
  localparam int SPRITE_DIM = 16;
  localparam int FB_ADDR_W  = 19;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } blit_state_t;

endpackage

// File: rtl/fb_addr_calc.sv
// Combinational pixel locator: object origin plus (row, col) offset gives the
// on-screen flag and the linear framebuffer address y*640 + x.
module fb_addr_calc
  import gfx_pkg::*;
#(
  parameter int SCREEN_W = gfx_pkg::SCREEN_W,
  parameter int SCREEN_H = gfx_pkg::SCREEN_H
) (
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [3:0]  row,
  input  logic [3:0]  col,
  output logic        on_screen,
  output logic [18:0] addr
);

  logic [10:0] px;
  logic [10:0] py;

  // 11-bit sums so an object near the right/bottom edge never wraps to 0
  always_comb begin
    px        = {1'b0, x} + {7'd0, col};
    py        = {1'b0, y} + {7'd0, row};
    on_screen = (px < 11'(SCREEN_W)) && (py < 11'(SCREEN_H));
    addr      = ({8'd0, py} << 9) + ({8'd0, py} << 7) + {8'd0, px};
  end

endmodule

// File: rtl/sprite_blitter.sv
// Rasterizes an object descriptor into the framebuffer, first erasing the
// object's previous footprint when it has moved or resized.
module sprite_blitter
  import gfx_pkg::*;
#(
  parameter int SCREEN_W   = gfx_pkg::SCREEN_W,
  parameter int SCREEN_H   = gfx_pkg::SCREEN_H,
  parameter int SPRITE_DIM = gfx_pkg::SPRITE_DIM,
  parameter int FB_ADDR_W  = gfx_pkg::FB_ADDR_W
) (
  input  logic                             CLOCK_50,
  input  logic                             reset,
  input  logic                             start,
  input  logic [9:0]                       obj_x,
  input  logic [9:0]                       obj_y,
  input  logic [9:0]                       obj_size,
  input  logic [SPRITE_DIM*SPRITE_DIM-1:0] obj_sprite,
  input  logic [7:0]                       obj_color,
  input  logic                             obj_write_enable,
  input  logic [7:0]                       bg_color,
  input  logic                             fb_ready,
  output logic [FB_ADDR_W-1:0]             fb_addr,
  output logic [7:0]                       fb_data,
  output logic                             fb_we,
  output logic                             busy,
  output logic                             done
);

  blit_state_t state, next_state;

  logic [9:0]   cur_x, cur_y, prev_x, prev_y, sel_x, sel_y;
  logic [4:0]   cur_size, prev_size, in_size, sel_size;
  logic [255:0] cur_sprite;
  logic [7:0]   cur_color;
  logic         cur_we, prev_valid;
  logic [8:0]   scan_cnt;
  logic [3:0]   row, col;
  logic         stall, scan_last, scan_end, pos_changed, erasing;
  logic         on_screen, in_box, pix_write;
  logic [18:0]  pix_addr;

  always_comb begin
    in_size     = (obj_size > 10'd16) ? 5'd16 : obj_size[4:0];
    pos_changed = (obj_x != prev_x) || (obj_y != prev_y) || (in_size != prev_size);
    stall       = fb_we && !fb_ready;
    scan_last   = (scan_cnt == 9'd255);
    scan_end    = scan_cnt[8];
    row         = scan_cnt[7:4];
    col         = scan_cnt[3:0];
    erasing     = (state == ERASE);
    sel_x       = erasing ? prev_x : cur_x;
    sel_y       = erasing ? prev_y : cur_y;
    sel_size    = erasing ? prev_size : cur_size;
    in_box      = ({1'b0, row} < sel_size) && ({1'b0, col} < sel_size);
    pix_write   = !scan_end && in_box && on_screen &&
                  (erasing || cur_sprite[~scan_cnt[7:0]]);
  end

  fb_addr_calc #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_addr (
    .x         (sel_x),
    .y         (sel_y),
    .row       (row),
    .col       (col),
    .on_screen (on_screen),
    .addr      (pix_addr)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Erase hands over to draw straight from its last position; a terminal scan
  // phase spends one extra cycle at scan_end so its last write is accepted.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (prev_valid && pos_changed) next_state = ERASE;
          else if (obj_write_enable)     next_state = DRAW;
          else                           next_state = DONE;
        end
      end
      ERASE: begin
        if (!stall) begin
          if (scan_last && cur_we) next_state = DRAW;
          else if (scan_end)       next_state = DONE;
        end
      end
      DRAW: begin
        if (!stall && scan_end) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
      done       <= 1'b0;
      scan_cnt   <= '0;
      prev_valid <= 1'b0;
      prev_x     <= '0;
      prev_y     <= '0;
      prev_size  <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
      cur_size   <= '0;
      cur_sprite <= '0;
      cur_color  <= '0;
      cur_we     <= 1'b0;
    end else begin
      done <= (next_state == DONE);
      if (state == IDLE && start) begin
        cur_x      <= obj_x;
        cur_y      <= obj_y;
        cur_size   <= in_size;
        cur_sprite <= obj_sprite;
        cur_color  <= obj_color;
        cur_we     <= obj_write_enable;
        scan_cnt   <= '0;
      end
      if ((state == ERASE || state == DRAW) && !stall) begin
        fb_we   <= pix_write;
        fb_addr <= pix_addr;
        fb_data <= erasing ? bg_color : cur_color;
        if (erasing && scan_last && cur_we) scan_cnt <= '0;
        else if (!scan_end)                 scan_cnt <= scan_cnt + 9'd1;
      end else if (state == IDLE || state == DONE) begin
        fb_we <= 1'b0;
      end
      // Only a completed draw leaves a footprint worth erasing later
      if (next_state == DONE) begin
        if (state == DRAW) begin
          prev_x     <= cur_x;
          prev_y     <= cur_y;
          prev_size  <= cur_size;
          prev_valid <= 1'b1;
        end else begin
          prev_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: table of descriptors with hand-computed
// write counts, addresses and done latencies, plus stall/busy/reset sequences.
module tb_sprite_blitter;

  logic         CLOCK_50 = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [9:0]   obj_x = '0, obj_y = '0, obj_size = '0;
  logic [255:0] obj_sprite = '0;
  logic [7:0]   obj_color = '0, bg_color = '0;
  logic         obj_write_enable = 1'b0;
  logic         fb_ready = 1'b1;
  logic [18:0]  fb_addr;
  logic [7:0]   fb_data;
  logic         fb_we, busy, done;

  int n_checks = 0;
  int n_pass = 0;
  int lat;
  int wr_addr[$];
  int wr_data[$];

  typedef struct {
    bit           rst;
    int           x, y, size;
    logic [255:0] sprite;
    int           color;
    bit           we;
    int           bg;
    int           exp_count, exp_lat;
    int           ia, aa, da;
    int           ib, ab, db;
  } vec_t;

  vec_t vecs[8];

  sprite_blitter dut (
    .CLOCK_50         (CLOCK_50),
    .reset            (reset),
    .start            (start),
    .obj_x            (obj_x),
    .obj_y            (obj_y),
    .obj_size         (obj_size),
    .obj_sprite       (obj_sprite),
    .obj_color        (obj_color),
    .obj_write_enable (obj_write_enable),
    .bg_color         (bg_color),
    .fb_ready         (fb_ready),
    .fb_addr          (fb_addr),
    .fb_data          (fb_data),
    .fb_we            (fb_we),
    .busy             (busy),
    .done             (done)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Writes are accepted at the rising edge; outputs are stable at the falling one
  always @(negedge CLOCK_50) begin
    if (fb_we && fb_ready) begin
      wr_addr.push_back(int'(fb_addr));
      wr_data.push_back(int'(fb_data));
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic doReset();
    @(negedge CLOCK_50);
    reset = 1'b1;
    @(posedge CLOCK_50);
    #1 reset = 1'b0;
  endtask

  task automatic waitDone(input int poke_at);
    while (!done && lat < 1200) begin
      @(posedge CLOCK_50);
      #1 lat++;
      start = (lat == poke_at);
      if (lat == poke_at) obj_x = 10'd200;
    end
    start = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int poke_at);
    if (v.rst) doReset();
    @(negedge CLOCK_50);
    obj_x            = 10'(v.x);
    obj_y            = 10'(v.y);
    obj_size         = 10'(v.size);
    obj_sprite       = v.sprite;
    obj_color        = 8'(v.color);
    obj_write_enable = v.we;
    bg_color         = 8'(v.bg);
    wr_addr.delete();
    wr_data.delete();
    start = 1'b1;
    @(posedge CLOCK_50);
    #1 start = 1'b0;
    lat = 0;
    waitDone(poke_at);
  endtask

  task automatic checkVector(input string tag, input vec_t v);
    checkOutput({tag, ".latency"}, lat, v.exp_lat);
    @(posedge CLOCK_50);
    #1;
    checkOutput({tag, ".done_pulse"}, done, 0);
    checkOutput({tag, ".idle_busy"}, busy, 0);
    checkOutput({tag, ".count"}, wr_addr.size(), v.exp_count);
    if (v.ia < v.exp_count && v.ia < wr_addr.size()) begin
      checkOutput({tag, ".addr_a"}, wr_addr[v.ia], v.aa);
      checkOutput({tag, ".data_a"}, wr_data[v.ia], v.da);
    end
    if (v.ib < v.exp_count && v.ib < wr_addr.size()) begin
      checkOutput({tag, ".addr_b"}, wr_addr[v.ib], v.ab);
      checkOutput({tag, ".data_b"}, wr_data[v.ib], v.db);
    end
  endtask

  initial begin
    logic [255:0] ones;
    logic [255:0] corners;
    vec_t v;
    bit stable;
    ones    = '1;
    corners = {1'b1, 254'd0, 1'b1};

    //          rst x    y    sz  sprite   col we bg cnt  lat  ia aa      da  ib   ab      db
    vecs[0] = '{1, 328, 232, 16, ones,    65, 1, 0, 256, 257, 0, 148808, 65, 255, 158423, 65};
    vecs[1] = '{0, 344, 232, 16, ones,    65, 1, 0, 512, 513, 0, 148808, 0,  256, 148824, 65};
    vecs[2] = '{1, 632, 472, 16, ones,    7,  1, 0, 64,  257, 0, 302712, 7,  63,  307199, 7};
    vecs[3] = '{1, 0,   0,   16, corners, 9,  1, 0, 2,   257, 0, 0,      9,  1,   9615,   9};
    vecs[4] = '{0, 0,   0,   16, ones,    9,  0, 0, 0,   0,   0, 0,      0,  0,   0,      0};
    vecs[5] = '{0, 0,   0,   16, ones,    12, 1, 0, 256, 257, 0, 0,      12, 255, 9615,   12};
    vecs[6] = '{0, 100, 0,   0,  ones,    12, 1, 3, 256, 513, 0, 0,      3,  255, 9615,   3};
    vecs[7] = '{0, 100, 0,   40, ones,    20, 1, 3, 256, 513, 0, 100,    20, 255, 9715,   20};

    doReset();
    #1;
    checkOutput("reset.fb_we", fb_we, 0);
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.done", done, 0);
    checkOutput("reset.fb_addr", fb_addr, 0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], -1);
      checkVector($sformatf("vec%0d", i), vecs[i]);
    end

    // First write held off by 10 stalled edges
    v = '{1, 0, 0, 16, ones, 5, 1, 0, 256, 267, 0, 0, 5, 255, 9615, 5};
    doReset();
    @(negedge CLOCK_50);
    fb_ready = 1'b0;
    obj_x = 10'd0; obj_y = 10'd0; obj_size = 10'd16; obj_sprite = ones;
    obj_color = 8'd5; obj_write_enable = 1'b1;
    wr_addr.delete();
    wr_data.delete();
    start = 1'b1;
    @(posedge CLOCK_50);
    #1 start = 1'b0;
    @(posedge CLOCK_50);
    #1 lat = 1;
    stable = 1'b1;
    repeat (10) begin
      @(posedge CLOCK_50);
      #1 lat++;
      if (!(fb_we && fb_addr == 19'd0 && fb_data == 8'd5)) stable = 1'b0;
    end
    checkOutput("stall.held_stable", stable, 1);
    fb_ready = 1'b1;
    waitDone(-1);
    checkVector("stall", v);

    // Start pulsed mid-draw with a new x must not disturb the run
    v = '{1, 0, 0, 16, ones, 1, 1, 0, 256, 257, 0, 0, 1, 255, 9615, 1};
    applyStimulus(v, 50);
    checkVector("busy_start", v);

    // Reset mid-draw, then a fresh start skips the erase
    v = '{1, 0, 0, 16, ones, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    doReset();
    @(negedge CLOCK_50);
    obj_x = 10'd0; obj_y = 10'd0; obj_size = 10'd16; obj_sprite = ones;
    obj_color = 8'd2; obj_write_enable = 1'b1;
    start = 1'b1;
    @(posedge CLOCK_50);
    #1 start = 1'b0;
    repeat (100) @(posedge CLOCK_50);
    #1 reset = 1'b1;
    @(posedge CLOCK_50);
    #1 reset = 1'b0;
    checkOutput("midreset.fb_we", fb_we, 0);
    checkOutput("midreset.busy", busy, 0);
    checkOutput("midreset.done", done, 0);
    v = '{0, 50, 0, 16, ones, 4, 1, 0, 256, 257, 0, 50, 4, 255, 9665, 4};
    applyStimulus(v, -1);
    checkVector("after_reset", v);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
